if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit MIPS pipeline. It owns the program counter, drives the word-aligned fetch address to the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It handles stall, flush and branch/jump redirects from the later stages. It traps misaligned redirect targets into a sticky fault state.

---
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction fetch; owns pc, drives the ROM address and fills the IF/ID register
// Ports: clk/reset (sync, active-high); stall/flush from decode; branch_taken/branch_target and
// jump/jump_target redirects; imem_addr/imem_data to the combinational ROM; if_id_instr/if_id_pc4/
// if_id_valid form the IF/ID register; fault is the sticky misaligned-redirect flag; fetch_count
// counts accepted instructions and saturates.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               fault,
  output logic [COUNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, instr_n, pc4_n, pc_plus4, target;
  logic valid_n, load, redirect;
  assign pc_plus4 = pc + 32'd4;
  assign redirect = branch_taken | jump;
  // the branch is the older instruction, so it wins over a simultaneous jump
  assign target = branch_taken ? branch_target : jump_target;
  assign imem_addr = pc;
  assign fault = state == FAULT;
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = if_id_instr;
    pc4_n = if_id_pc4;
    valid_n = if_id_valid;
    load = 1'b0;
    case (state)
      BOOT: begin
        state_n = FETCH;
        instr_n = '0;
        valid_n = 1'b0;
      end
      FETCH: begin
        if (redirect) begin
          instr_n = '0;
          valid_n = 1'b0;
          state_n = |target[1:0] ? FAULT : FETCH;
          pc_n = |target[1:0] ? pc : target;
        end else if (stall) begin
          instr_n = flush ? '0 : if_id_instr;
          valid_n = flush ? 1'b0 : if_id_valid;
        end else if (flush) begin
          instr_n = '0;
          valid_n = 1'b0;
          pc_n = pc_plus4;
        end else begin
          pc_n = pc_plus4;
          instr_n = imem_data;
          pc4_n = pc_plus4;
          valid_n = 1'b1;
          load = 1'b1;
        end
      end
      default: begin
        instr_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4 <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc4 <= pc4_n;
      if_id_valid <= valid_n;
      if (load && !(&fetch_count)) fetch_count <= fetch_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of if_fetch_stage, plus a wrap/saturation instance
module tb_if_fetch_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_addr, imem_data, if_id_instr, if_id_pc4;
  logic if_id_valid, fault;
  logic [15:0] fetch_count;
  logic reset1;
  logic [31:0] imem_addr1, imem_data1, if_id_instr1, if_id_pc41;
  logic if_id_valid1, fault1;
  logic [1:0] fetch_count1;
  int n_cmp = 0, n_bad = 0;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'h8c020004 : a == 32'h4 ? 32'h00421020 : 32'h20000000 ^ a;
  endfunction
  assign imem_data = rom(imem_addr);
  assign imem_data1 = rom(imem_addr1);
  if_fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fault(fault), .fetch_count(fetch_count)
  );
  if_fetch_stage #(.RESET_PC(32'hFFFFFFFC), .COUNT_W(2)) u_wrap (
    .clk(clk), .reset(reset1), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0), .jump(1'b0), .jump_target(32'h0),
    .imem_addr(imem_addr1), .imem_data(imem_data1),
    .if_id_instr(if_id_instr1), .if_id_pc4(if_id_pc41), .if_id_valid(if_id_valid1),
    .fault(fault1), .fetch_count(fetch_count1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
    check({tag, ".addr"}, imem_addr, pc);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"}, if_id_pc4, pc4);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    check({tag, ".count"}, {16'b0, fetch_count}, cnt);
  endtask
  initial begin
    reset = 1; reset1 = 1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    tick();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0);
    check("reset.fault", {31'b0, fault}, 0);
    reset = 0;
    tick();
    check_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0, 0);
    tick();
    check_ifid("load0", 32'h4, 32'h8c020004, 32'h4, 1'b1, 1);
    tick();
    check_ifid("load4", 32'h8, 32'h00421020, 32'h8, 1'b1, 2);
    tick(2);
    check_ifid("run", 32'h10, rom(32'hC), 32'h10, 1'b1, 4);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ifid("stall", 32'h10, rom(32'hC), 32'h10, 1'b1, 4);
    end
    stall = 0;
    tick();
    check_ifid("resume", 32'h14, rom(32'h10), 32'h14, 1'b1, 5);
    tick(4);
    check("pre_jump.addr", imem_addr, 32'h24);
    jump = 1; jump_target = 32'h34;
    tick();
    jump = 0;
    check_ifid("jump", 32'h34, 32'h0, 32'h24, 1'b0, 9);
    tick();
    check_ifid("jump_land", 32'h38, rom(32'h34), 32'h38, 1'b1, 10);
    flush = 1;
    tick();
    flush = 0;
    check_ifid("flush", 32'h3C, 32'h0, 32'h38, 1'b0, 10);
    tick();
    check_ifid("post_flush", 32'h40, rom(32'h3C), 32'h40, 1'b1, 11);
    branch_taken = 1; branch_target = 32'h60; jump = 1; jump_target = 32'h80; stall = 1;
    tick();
    branch_taken = 0; jump = 0; stall = 0;
    check_ifid("br_vs_jump", 32'h60, 32'h0, 32'h40, 1'b0, 11);
    tick();
    check_ifid("br_land", 32'h64, rom(32'h60), 32'h64, 1'b1, 12);
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    check_ifid("stall_flush", 32'h64, 32'h0, 32'h64, 1'b0, 12);
    tick();
    check_ifid("sf_resume", 32'h68, rom(32'h64), 32'h68, 1'b1, 13);
    branch_taken = 1; branch_target = 32'h42;
    tick();
    branch_taken = 0;
    check("fault.flag", {31'b0, fault}, 1);
    check_ifid("fault", 32'h68, 32'h0, 32'h68, 1'b0, 13);
    jump = 1; jump_target = 32'h100;
    tick(3);
    jump = 0;
    check("fault.sticky", {31'b0, fault}, 1);
    check_ifid("fault_jump", 32'h68, 32'h0, 32'h68, 1'b0, 13);
    reset = 1; jump = 1; jump_target = 32'h200;
    tick();
    reset = 0; jump = 0;
    check("rst.fault", {31'b0, fault}, 0);
    check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0, 0);
    tick(2);
    check_ifid("rst_run", 32'h4, 32'h8c020004, 32'h4, 1'b1, 1);
    reset1 = 1;
    tick();
    reset1 = 0;
    check("wrap.reset", imem_addr1, 32'hFFFFFFFC);
    tick();
    check("wrap.boot", imem_addr1, 32'hFFFFFFFC);
    tick();
    check("wrap.addr", imem_addr1, 32'h0);
    check("wrap.pc4", if_id_pc41, 32'h0);
    check("wrap.instr", if_id_instr1, 32'hDFFFFFFC);
    check("wrap.count1", {30'b0, fetch_count1}, 1);
    tick(2);
    check("sat.count3", {30'b0, fetch_count1}, 3);
    tick(2);
    check("sat.count5", {30'b0, fetch_count1}, 3);
    check("sat.addr", imem_addr1, 32'h10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
